// File: rtl/sa_pkg.sv
// Shared types and constants for the 2x2 systolic array and its result drain.
package sa_pkg;

    localparam int SA_ACC_WIDTH = 9;

    // One completed C tile, element 0 = c00 in the low bits.
    typedef logic [3:0][SA_ACC_WIDTH-1:0] c_tile_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

    // Row-major element index {row,col}.
    localparam logic [1:0] IDX_C00 = 2'd0;
    localparam logic [1:0] IDX_C01 = 2'd1;
    localparam logic [1:0] IDX_C10 = 2'd2;
    localparam logic [1:0] IDX_C11 = 2'd3;

endpackage

// File: rtl/result_fifo.sv
// Single-clock tile FIFO. Pointers carry an extra MSB so full and empty are
// distinguishable. The head entry is read combinationally. A write to a full
// FIFO is legal only together with a pop, in which case it lands in the slot
// the head is leaving.
module result_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    // Read/write pointers, cleared immediately on reset to discard all tiles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Captures C tiles from the systolic array into a tile FIFO and streams them
// out row-major, one element per beat, over valid/ready with a last flag.
// Tiles that arrive while the FIFO is full (and the head is not leaving in the
// same cycle) are dropped and counted.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | FIFO empty, m_valid low
// STREAM | presenting element k_q of the head tile, m_valid high
module systolic_result_drain
    import sa_pkg::*;
#(
    parameter int ACC_WIDTH = SA_ACC_WIDTH,
    parameter int DEPTH     = 4,
    parameter int DROP_W    = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cap_valid,
    input  logic [ACC_WIDTH-1:0]     cap_c00,
    input  logic [ACC_WIDTH-1:0]     cap_c01,
    input  logic [ACC_WIDTH-1:0]     cap_c10,
    input  logic [ACC_WIDTH-1:0]     cap_c11,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [ACC_WIDTH-1:0]     m_data,
    output logic [1:0]               m_idx,
    output logic                     m_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic [3:0][ACC_WIDTH-1:0] cap_tile;
    logic [3:0][ACC_WIDTH-1:0] head_tile;
    logic [4*ACC_WIDTH-1:0]    fifo_rdata;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [LW-1:0]             fifo_level;

    drain_state_t              state_q, state_d;
    logic [1:0]                k_q, k_d;

    logic                      hs;
    logic                      pop;
    logic                      push_ok;
    logic                      drop;
    logic                      more_tiles;

    logic                      ovf_q;
    logic [DROP_W-1:0]         drop_cnt_q;

    assign cap_tile  = {cap_c11, cap_c10, cap_c01, cap_c00};
    assign head_tile = fifo_rdata;

    assign hs      = m_valid && m_ready;
    assign pop     = hs && (k_q == IDX_C11);
    assign push_ok = cap_valid && (!fifo_full || pop);
    assign drop    = cap_valid && !push_ok;

    // Another tile will be at the head after this pop, counting a same-cycle push.
    assign more_tiles = (fifo_level > LW'(1)) || push_ok;

    result_fifo #(
        .WIDTH (4*ACC_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push_ok),
        .wdata_i (cap_tile),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // FSM state and element-index registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            k_q     <= IDX_C00;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Next state: a push from IDLE starts streaming on the following cycle;
    // the last-element handshake either rolls straight into the next tile or idles.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                k_d = IDX_C00;
                if (push_ok || !fifo_empty) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (hs) begin
                    if (k_q == IDX_C11) begin
                        k_d     = IDX_C00;
                        state_d = more_tiles ? STREAM : IDLE;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = IDX_C00;
            end
        endcase
    end

    // Output mux; everything reads zero when nothing is being presented.
    always_comb begin
        m_valid = (state_q == STREAM);
        m_data  = '0;
        m_idx   = IDX_C00;
        m_last  = 1'b0;
        if (m_valid) begin
            m_data = head_tile[k_q];
            m_idx  = k_q;
            m_last = (k_q == IDX_C11);
        end
    end

    // Sticky overflow flag and saturating drop counter; a drop beats a clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (ovf_clr) begin
                drop_cnt_q <= DROP_W'(1);
            end else if (drop_cnt_q != {DROP_W{1'b1}}) begin
                drop_cnt_q <= drop_cnt_q + DROP_W'(1);
            end
        end else if (ovf_clr) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end
    end

    assign level    = fifo_level;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: single tile, backpressure,
// back-to-back tiles, overflow/clear/saturation, full-with-pop and mid-stream reset.
module tb_systolic_result_drain;

    localparam int ACC_WIDTH = 9;
    localparam int DEPTH     = 4;
    localparam int DROP_W    = 8;
    localparam int LW        = $clog2(DEPTH) + 1;

    logic                 clk;
    logic                 rstn;
    logic                 cap_valid;
    logic [ACC_WIDTH-1:0] cap_c00, cap_c01, cap_c10, cap_c11;
    logic                 m_valid;
    logic                 m_ready;
    logic [ACC_WIDTH-1:0] m_data;
    logic [1:0]           m_idx;
    logic                 m_last;
    logic [LW-1:0]        level;
    logic                 ovf;
    logic                 ovf_clr;
    logic [DROP_W-1:0]    drop_cnt;

    int vecs = 0;
    int errs = 0;

    systolic_result_drain #(
        .ACC_WIDTH (ACC_WIDTH),
        .DEPTH     (DEPTH),
        .DROP_W    (DROP_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cap_valid (cap_valid),
        .cap_c00   (cap_c00),
        .cap_c01   (cap_c01),
        .cap_c10   (cap_c10),
        .cap_c11   (cap_c11),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_idx     (m_idx),
        .m_last    (m_last),
        .level     (level),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive a tile whose elements are base, base+1, base+2, base+3.
    task automatic set_tile(input int base);
        cap_valid = 1'b1;
        cap_c00   = ACC_WIDTH'(base);
        cap_c01   = ACC_WIDTH'(base + 1);
        cap_c10   = ACC_WIDTH'(base + 2);
        cap_c11   = ACC_WIDTH'(base + 3);
    endtask

    // Check the beat currently presented.
    task automatic chk_beat(input string tag, input int base, input int k);
        chk({tag, "_valid"}, 32'(m_valid), 32'd1);
        chk({tag, "_data"},  32'(m_data),  32'(base + k));
        chk({tag, "_idx"},   32'(m_idx),   32'(k));
        chk({tag, "_last"},  32'(m_last),  32'(k == 3));
    endtask

    initial begin
        int bases[8];

        rstn      = 1'b0;
        cap_valid = 1'b0;
        cap_c00   = '0;
        cap_c01   = '0;
        cap_c10   = '0;
        cap_c11   = '0;
        m_ready   = 1'b0;
        ovf_clr   = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data",  32'(m_data),  32'd0);
        chk("rst_idx",   32'(m_idx),   32'd0);
        chk("rst_last",  32'(m_last),  32'd0);
        chk("rst_level", 32'(level),   32'd0);
        chk("rst_ovf",   32'(ovf),     32'd0);
        chk("rst_drop",  32'(drop_cnt), 32'd0);
        rstn = 1'b1;
        tick();

        // 1: single tile 1,2,3,4 with m_ready high
        m_ready = 1'b1;
        set_tile(1);
        tick();
        cap_valid = 1'b0;
        chk("t1_level", 32'(level), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk_beat("t1", 1, k);
            tick();
        end
        chk("t1_idle_valid", 32'(m_valid), 32'd0);
        chk("t1_idle_level", 32'(level),   32'd0);

        // 2: backpressure for 5 cycles at idx1
        set_tile(5);
        tick();
        cap_valid = 1'b0;
        chk_beat("t2_b0", 5, 0);
        tick();
        chk_beat("t2_b1", 5, 1);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_beat("t2_hold", 5, 1);
        end
        m_ready = 1'b1;
        tick();
        chk_beat("t2_b2", 5, 2);
        tick();
        chk_beat("t2_b3", 5, 3);
        tick();
        chk("t2_idle", 32'(m_valid), 32'd0);

        // 3: tiles A (10..) and B (20..) captured two cycles apart, no bubble
        for (int i = 0; i < 4; i++) begin
            bases[i]     = 10;
            bases[i + 4] = 20;
        end
        set_tile(10);
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i == 1) set_tile(20);
            else        cap_valid = 1'b0;
            chk_beat("t3", bases[i], i % 4);
            tick();
        end
        cap_valid = 1'b0;
        chk("t3_idle", 32'(m_valid), 32'd0);
        chk("t3_level", 32'(level), 32'd0);

        // 4: overflow with the consumer stalled
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            set_tile(32'h40 + 4 * i);
            tick();
        end
        cap_valid = 1'b0;
        chk("t4_level", 32'(level),    32'(DEPTH));
        chk("t4_ovf",   32'(ovf),      32'd1);
        chk("t4_drop",  32'(drop_cnt), 32'd2);
        // drop and clear in the same cycle: the drop wins
        set_tile(32'h1F0);
        ovf_clr = 1'b1;
        tick();
        cap_valid = 1'b0;
        ovf_clr   = 1'b0;
        chk("t4_win_ovf",  32'(ovf),      32'd1);
        chk("t4_win_drop", 32'(drop_cnt), 32'd1);
        // saturation of the drop counter
        set_tile(32'h1F0);
        for (int i = 0; i < 260; i++) tick();
        cap_valid = 1'b0;
        chk("t4_sat_drop",  32'(drop_cnt), 32'd255);
        chk("t4_sat_level", 32'(level),    32'(DEPTH));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t4_clr_ovf",  32'(ovf),      32'd0);
        chk("t4_clr_drop", 32'(drop_cnt), 32'd0);
        m_ready = 1'b1;
        for (int t = 0; t < DEPTH; t++) begin
            for (int k = 0; k < 4; k++) begin
                chk_beat("t4_drain", 32'h40 + 4 * t, k);
                tick();
            end
        end
        chk("t4_idle",  32'(m_valid), 32'd0);
        chk("t4_level0", 32'(level),  32'd0);

        // 5: capture while full in the same cycle as the last-element handshake
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_tile(32'h80 + 4 * i);
            tick();
        end
        cap_valid = 1'b0;
        chk("t5_full", 32'(level), 32'(DEPTH));
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk_beat("t5_head", 32'h80, k);
            if (k == 3) set_tile(32'hC0);
            tick();
        end
        cap_valid = 1'b0;
        chk("t5_level", 32'(level),    32'(DEPTH));
        chk("t5_drop",  32'(drop_cnt), 32'd0);
        chk("t5_ovf",   32'(ovf),      32'd0);
        bases[0] = 32'h84;
        bases[1] = 32'h88;
        bases[2] = 32'h8C;
        bases[3] = 32'hC0;
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 4; k++) begin
                chk_beat("t5_drain", bases[t], k);
                tick();
            end
        end
        chk("t5_idle", 32'(m_valid), 32'd0);

        // 6: reset while streaming idx2 with two tiles queued behind
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_tile(32'h60 + 4 * i);
            tick();
        end
        cap_valid = 1'b0;
        m_ready   = 1'b1;
        tick();
        tick();
        chk_beat("t6_pre", 32'h60, 2);
        chk("t6_pre_level", 32'(level), 32'd3);
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(m_valid), 32'd0);
        chk("t6_rst_data",  32'(m_data),  32'd0);
        chk("t6_rst_idx",   32'(m_idx),   32'd0);
        chk("t6_rst_last",  32'(m_last),  32'd0);
        chk("t6_rst_level", 32'(level),   32'd0);
        tick();
        rstn = 1'b1;
        tick();
        tick();
        chk("t6_stale_valid", 32'(m_valid), 32'd0);
        chk("t6_stale_level", 32'(level),   32'd0);
        set_tile(32'h1A);
        tick();
        cap_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_beat("t6_new", 32'h1A, k);
            tick();
        end
        chk("t6_idle", 32'(m_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
